// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {RUN, MD_BUSY} hz_state_t;

  localparam int          REG_AW = 5;
  localparam logic [31:0] NOP    = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in EX whose rd feeds rs1/rs2 of the ID instruction.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic [AW-1:0] rd_i,
  input  logic          mem_read_i,
  output logic          hazard_o
);

  // x0 is hard-wired zero, so a load targeting it never produces a dependency
  assign hazard_o = mem_read_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch squash, MUL/DIV handshake and stall statistics.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = hazard_pkg::REG_AW,
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_md_op,
  input  logic              branch_taken,
  input  logic              md_done,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_bubble,
  output logic              md_start,
  output logic              md_error,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int               TO_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MD_TIMEOUT - 1);

  hz_state_t          state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               md_error_q, md_error_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               load_use;

  load_use_detect #(.AW(REG_AW)) u_lud (
    .rs1_i      (if_id_rs1),
    .rs2_i      (if_id_rs2),
    .rd_i       (id_ex_rd),
    .mem_read_i (id_ex_mem_read),
    .hazard_o   (load_use)
  );

  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    md_error_d    = md_error_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_ex_md_op) begin
          md_start      = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          to_cnt_d      = '0;
          state_d       = MD_BUSY;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MD_BUSY: begin
        if (md_done) begin
          // result lands in EX/MEM this cycle, so the whole pipe may advance
          to_cnt_d = '0;
          state_d  = RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          if (to_cnt_q == TO_LAST) begin
            md_error_d = 1'b1;
            to_cnt_d   = '0;
            state_d    = RUN;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    // hold the pipe in its free-running configuration while reset is asserted
    if (!rst_n) begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      md_start      = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      to_cnt_q   <= '0;
      md_error_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      md_error_q <= md_error_d;
      stall_q    <= stall_d;
    end
  end

  assign md_error    = md_error_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random checks of pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 6;
  localparam int TMO   = 8;
  localparam int SAT   = (1 << CNT_W) - 1;
  // control vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, md_start
  localparam logic [6:0] C_FREE = 7'b1101000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic mr = 1'b0, md = 1'b0, br = 1'b0, dn = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, md_start, md_error;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_busy = 0, m_cyc = 0, m_err = 0, m_stall = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W), .MD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .id_ex_rd(rd),
    .id_ex_mem_read(mr), .id_ex_md_op(md), .branch_taken(br), .md_done(dn),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .md_start(md_start), .md_error(md_error), .stall_count(stall_count)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, md_start};
  endfunction

  task automatic step(input int a1, input int a2, input int d, input bit lm, input bit mo,
                      input bit bt, input bit done);
    logic [6:0] e;
    @(negedge clk);
    rs1 = 5'(a1); rs2 = 5'(a2); rd = 5'(d); mr = lm; md = mo; br = bt; dn = done;
    #1;
    e = C_FREE;
    if (!m_busy) begin
      if (bt)                                          e = 7'b1111100;
      else if (mo)                                     e = 7'b0000011;
      else if (lm && d != 0 && (d == a1 || d == a2))   e = 7'b0001100;
    end else if (!done) begin
      e = 7'b0000010;
    end
    check_eq("ctl", ctl_now(), e);
    @(posedge clk);
    #1;
    if (!e[6]) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
    if (!m_busy) begin
      if (!bt && mo) begin m_busy = 1; m_cyc = 0; end
    end else if (done) begin
      m_busy = 0;
    end else begin
      m_cyc++;
      if (m_cyc == TMO) begin m_err = 1; m_busy = 0; end
    end
    check_eq("stall_count", stall_count, m_stall);
    check_eq("md_error", md_error, m_err);
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask

  // assert reset at a non-edge time with an MD op on the inputs; nothing may leak out
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rs1 = 5'd3; rs2 = 5'd3; rd = 5'd3; mr = 1'b1; md = 1'b1; br = 1'b0; dn = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ctl", ctl_now(), C_FREE);
    check_eq("rst_stall", stall_count, 0);
    check_eq("rst_err", md_error, 0);
    m_busy = 0; m_cyc = 0; m_err = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_ctl", ctl_now(), C_FREE);
    @(negedge clk);
    md = 1'b0; mr = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    apply_reset();

    // load-use on rs1: single bubble
    step(5, 1, 5, 1, 0, 0, 0);
    check_eq("lu_stall1", stall_count, 1);
    idle();
    // rd = x0 never stalls; rs2 match stalls; no match with rs1=rs2=3
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 7, 7, 1, 0, 0, 0);
    step(3, 3, 7, 1, 0, 0, 0);
    check_eq("lu_stall2", stall_count, 2);
    // branch overrides a load-use match
    step(5, 5, 5, 1, 0, 1, 0);
    check_eq("br_ctl", ctl_now() == 7'b0 ? 0 : {25'd0, pc_write, if_id_flush, id_ex_flush}, 7);

    // MUL/DIV: start cycle + 4 busy cycles, done on the 5th busy cycle
    s0 = m_stall;
    step(0, 0, 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    check_eq("md_stall5", stall_count - CNT_W'(s0), 5);
    idle();

    // MD timeout: 8 busy cycles, then back in RUN with sticky error
    step(0, 0, 0, 0, 1, 0, 0);
    repeat (TMO) step(0, 0, 0, 0, 0, 0, 0);
    check_eq("md_err_set", md_error, 1);
    idle();
    step(2, 0, 2, 1, 0, 0, 0);
    check_eq("md_err_hold", md_error, 1);

    // reset in the middle of MD_BUSY
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    apply_reset();
    idle();

    // random traffic, with a reset between batches; long enough to saturate the counter
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 300; i++) begin
        bit mo, bt;
        mo = ($urandom % 6) == 0;
        bt = !mo && (($urandom % 5) == 0);
        step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom % 2), mo, bt, ($urandom % 4) == 0);
      end
      if (b == 0) apply_reset();
    end
    check_eq("sat_stall", stall_count, SAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
